// File: rtl/unipolar_step_sequencer.sv
// Unipolar stepper phase sequencer: turns a divided step clock into the four
// coil drives for wave, full-step and half-step modes, and tracks absolute position.
module unipolar_step_sequencer #(
   parameter int unsigned COUNT_W = 16
) (
   input  logic               in_clk,
   input  logic               reset_n,
   input  logic               step_clk,
   input  logic [1:0]         mode,
   input  logic               dir,
   input  logic               hold_en,
   input  logic               start,
   input  logic               stop,
   input  logic [COUNT_W-1:0] move_steps,
   output logic [3:0]         coils,
   output logic               busy,
   output logic               done,
   output logic [COUNT_W-1:0] position
);

   localparam int unsigned PHASE_W = 3;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   state_t               state;
   logic                 step_sync1;
   logic                 step_sync2;
   logic                 step_hist;
   logic                 tick_c;
   logic [PHASE_W-1:0]   phase;
   logic [PHASE_W-1:0]   phase_step_c;
   logic [PHASE_W-1:0]   phase_nxt_c;
   logic [COUNT_W-1:0]   pos_nxt_c;
   logic [COUNT_W-1:0]   remaining;
   logic [1:0]           mode_q;
   logic                 dir_q;

   // Eight-entry half-step table; wave and full use the even and odd entries
   function automatic logic [3:0] half_pattern(input logic [PHASE_W-1:0] idx);
      logic [3:0] pat;
      case (idx)
         3'd0:    pat = 4'b1000;
         3'd1:    pat = 4'b1100;
         3'd2:    pat = 4'b0100;
         3'd3:    pat = 4'b0110;
         3'd4:    pat = 4'b0010;
         3'd5:    pat = 4'b0011;
         3'd6:    pat = 4'b0001;
         default: pat = 4'b1001;
      endcase
      return pat;
   endfunction

   // Mode 1x reads the table directly; wave forces idx[0]=0, full forces idx[0]=1
   function automatic logic [3:0] coil_pattern(input logic [PHASE_W-1:0] ph,
                                               input logic [1:0]         md);
      logic [3:0] pat;
      if (md[1]) begin
         pat = half_pattern(ph);
      end else begin
         pat = half_pattern({ph[2:1], md[0]});
      end
      return pat;
   endfunction

   // Two-flop synchroniser plus history flop for rising-edge detection of step_clk
   always_ff @(posedge in_clk or negedge reset_n) begin
      if (!reset_n) begin
         step_sync1 <= 1'b0;
         step_sync2 <= 1'b0;
         step_hist  <= 1'b0;
      end else begin
         step_sync1 <= step_clk;
         step_sync2 <= step_sync1;
         step_hist  <= step_sync2;
      end
   end

   assign tick_c = step_sync2 & ~step_hist;

   // Next phase and position for one step in the latched direction and mode
   always_comb begin
      phase_step_c = mode_q[1] ? PHASE_W'(1) : PHASE_W'(2);
      phase_nxt_c  = dir_q ? (phase + phase_step_c) : (phase - phase_step_c);
      pos_nxt_c    = dir_q ? (position + COUNT_W'(1)) : (position - COUNT_W'(1));
   end

   // Move controller: latches the command, steps on ticks, drives registered outputs
   always_ff @(posedge in_clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= ST_IDLE;
         coils     <= 4'b0000;
         busy      <= 1'b0;
         done      <= 1'b0;
         position  <= '0;
         phase     <= '0;
         remaining <= '0;
         mode_q    <= 2'b00;
         dir_q     <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               busy  <= 1'b0;
               coils <= hold_en ? coil_pattern(phase, mode_q) : 4'b0000;
               if (start) begin
                  mode_q    <= mode;
                  dir_q     <= dir;
                  remaining <= move_steps;
                  state     <= ST_RUN;
                  busy      <= 1'b1;
                  coils     <= coil_pattern(phase, mode);
               end
            end
            ST_RUN: begin
               busy  <= 1'b1;
               coils <= coil_pattern(phase, mode_q);
               if (stop) begin
                  // Abort wins over a coincident tick: no step is taken
                  state <= ST_IDLE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  coils <= hold_en ? coil_pattern(phase, mode_q) : 4'b0000;
               end else if (tick_c) begin
                  phase    <= phase_nxt_c;
                  position <= pos_nxt_c;
                  coils    <= coil_pattern(phase_nxt_c, mode_q);
                  // A zero step count means continuous motion until stop
                  if (remaining != '0) begin
                     remaining <= remaining - COUNT_W'(1);
                     if (remaining == COUNT_W'(1)) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        coils <= hold_en ? coil_pattern(phase_nxt_c, mode_q) : 4'b0000;
                     end
                  end
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_unipolar_step_sequencer.sv
// Directed bench for unipolar_step_sequencer: vector table plus corner-case sequences.
module tb_unipolar_step_sequencer;

   localparam int unsigned COUNT_W = 16;
   localparam int OP_RST   = 0;
   localparam int OP_START = 1;
   localparam int OP_STEP  = 2;
   localparam int NVEC     = 17;

   logic               in_clk = 1'b0;
   logic               reset_n = 1'b0;
   logic               step_clk = 1'b0;
   logic [1:0]         mode = 2'b00;
   logic               dir = 1'b0;
   logic               hold_en = 1'b1;
   logic               start = 1'b0;
   logic               stop = 1'b0;
   logic [COUNT_W-1:0] move_steps = '0;
   logic [3:0]         coils;
   logic               busy;
   logic               done;
   logic [COUNT_W-1:0] position;

   int total = 0;
   int bad = 0;
   int done_seen = 0;

   typedef struct {
      int          op;
      logic [1:0]  md;
      logic        dr;
      logic [15:0] steps;
      logic [3:0]  exp_coils;
      logic        exp_busy;
      logic [15:0] exp_pos;
      int          exp_done;
   } vec_t;

   vec_t tbl [NVEC];

   unipolar_step_sequencer #(.COUNT_W(COUNT_W)) dut (
      .in_clk     (in_clk),
      .reset_n    (reset_n),
      .step_clk   (step_clk),
      .mode       (mode),
      .dir        (dir),
      .hold_en    (hold_en),
      .start      (start),
      .stop       (stop),
      .move_steps (move_steps),
      .coils      (coils),
      .busy       (busy),
      .done       (done),
      .position   (position)
   );

   always #5 in_clk = ~in_clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
      total++;
      if (act !== exp_v) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp_v);
      end
   endtask

   // Advance n cycles, sampling done on each falling edge
   task automatic cyc(input int n);
      repeat (n) begin
         @(negedge in_clk);
         if (done === 1'b1) done_seen++;
      end
   endtask

   task automatic do_step();
      step_clk = 1'b1;
      cyc(3);
      step_clk = 1'b0;
      cyc(3);
   endtask

   task automatic do_start(input logic [1:0] md, input logic dr, input logic [15:0] st);
      mode = md;
      dir = dr;
      move_steps = st;
      start = 1'b1;
      cyc(1);
      start = 1'b0;
      cyc(1);
   endtask

   task automatic do_stop();
      stop = 1'b1;
      cyc(1);
      stop = 1'b0;
      cyc(2);
   endtask

   task automatic check_state(input string nm, input logic [3:0] c, input logic b,
                              input logic [15:0] p);
      chk({nm, " coils"}, 32'(coils), 32'(c));
      chk({nm, " busy"}, 32'(busy), 32'(b));
      chk({nm, " position"}, 32'(position), 32'(p));
   endtask

   initial begin
      logic [3:0] exp_wave [10];
      exp_wave = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001,
                   4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};

      //         op        mode   dir   steps  coils    busy  pos       done
      tbl[0]  = '{OP_RST,   2'b00, 1'b0, 16'd0, 4'b0000, 1'b0, 16'h0000, 0};
      tbl[1]  = '{OP_START, 2'b10, 1'b1, 16'd4, 4'b1000, 1'b1, 16'h0000, 0};
      tbl[2]  = '{OP_STEP,  2'b00, 1'b0, 16'd0, 4'b1100, 1'b1, 16'h0001, 0};
      tbl[3]  = '{OP_STEP,  2'b00, 1'b0, 16'd0, 4'b0100, 1'b1, 16'h0002, 0};
      tbl[4]  = '{OP_STEP,  2'b00, 1'b0, 16'd0, 4'b0110, 1'b1, 16'h0003, 0};
      tbl[5]  = '{OP_STEP,  2'b00, 1'b0, 16'd0, 4'b0010, 1'b0, 16'h0004, 1};
      tbl[6]  = '{OP_STEP,  2'b00, 1'b0, 16'd0, 4'b0010, 1'b0, 16'h0004, 0};
      tbl[7]  = '{OP_RST,   2'b00, 1'b0, 16'd0, 4'b0000, 1'b0, 16'h0000, 0};
      tbl[8]  = '{OP_START, 2'b01, 1'b0, 16'd3, 4'b1100, 1'b1, 16'h0000, 0};
      tbl[9]  = '{OP_STEP,  2'b00, 1'b0, 16'd0, 4'b1001, 1'b1, 16'hFFFF, 0};
      tbl[10] = '{OP_STEP,  2'b00, 1'b0, 16'd0, 4'b0011, 1'b1, 16'hFFFE, 0};
      tbl[11] = '{OP_STEP,  2'b00, 1'b0, 16'd0, 4'b0110, 1'b0, 16'hFFFD, 1};
      tbl[12] = '{OP_START, 2'b11, 1'b1, 16'd2, 4'b0100, 1'b1, 16'hFFFD, 0};
      tbl[13] = '{OP_STEP,  2'b00, 1'b0, 16'd0, 4'b0110, 1'b1, 16'hFFFE, 0};
      tbl[14] = '{OP_STEP,  2'b00, 1'b0, 16'd0, 4'b0010, 1'b0, 16'hFFFF, 1};
      tbl[15] = '{OP_START, 2'b00, 1'b1, 16'd1, 4'b0010, 1'b1, 16'hFFFF, 0};
      tbl[16] = '{OP_STEP,  2'b00, 1'b0, 16'd0, 4'b0001, 1'b0, 16'h0000, 1};

      @(negedge in_clk);
      for (int i = 0; i < NVEC; i++) begin
         done_seen = 0;
         if (tbl[i].op == OP_RST) begin
            reset_n = 1'b0;
            #1;
            check_state($sformatf("v%0d", i), tbl[i].exp_coils, tbl[i].exp_busy,
                        tbl[i].exp_pos);
            @(negedge in_clk);
            reset_n = 1'b1;
            cyc(2);
         end else begin
            if (tbl[i].op == OP_START) do_start(tbl[i].md, tbl[i].dr, tbl[i].steps);
            else do_step();
            check_state($sformatf("v%0d", i), tbl[i].exp_coils, tbl[i].exp_busy,
                        tbl[i].exp_pos);
         end
         chk($sformatf("v%0d done", i), 32'(done_seen), 32'(tbl[i].exp_done));
      end

      // Continuous reverse wave drive, then stop
      reset_n = 1'b0;
      #1;
      @(negedge in_clk);
      reset_n = 1'b1;
      cyc(2);
      do_start(2'b00, 1'b0, 16'd0);
      for (int i = 0; i < 10; i++) begin
         do_step();
         check_state($sformatf("wave%0d", i), exp_wave[i], 1'b1, 16'(16'h0000 - 16'(i + 1)));
      end
      done_seen = 0;
      do_stop();
      chk("wave stop done", 32'(done_seen), 32'd1);
      check_state("wave stop", 4'b0010, 1'b0, 16'hFFF6);
      do_step();
      check_state("wave after stop", 4'b0010, 1'b0, 16'hFFF6);

      // Hold torque toggling in idle
      hold_en = 1'b0;
      cyc(2);
      chk("hold off coils", 32'(coils), 32'h0);
      hold_en = 1'b1;
      cyc(2);
      chk("hold on coils", 32'(coils), 32'b0010);

      // Stop coincident with a tick: no step
      do_start(2'b10, 1'b1, 16'd0);
      done_seen = 0;
      step_clk = 1'b1;
      cyc(2);
      stop = 1'b1;
      cyc(1);
      stop = 1'b0;
      cyc(1);
      step_clk = 1'b0;
      cyc(3);
      chk("stop+tick done", 32'(done_seen), 32'd1);
      check_state("stop+tick", 4'b0010, 1'b0, 16'hFFF6);

      // Start coincident with a tick: tick ignored, next tick steps
      step_clk = 1'b1;
      cyc(2);
      mode = 2'b10;
      dir = 1'b1;
      move_steps = 16'd1;
      start = 1'b1;
      cyc(1);
      start = 1'b0;
      cyc(1);
      step_clk = 1'b0;
      cyc(3);
      check_state("start+tick", 4'b0010, 1'b1, 16'hFFF6);
      done_seen = 0;
      do_step();
      check_state("start+tick next", 4'b0011, 1'b0, 16'hFFF7);
      chk("start+tick done", 32'(done_seen), 32'd1);

      // Reset mid-move at position 7, then resume from phase 0
      reset_n = 1'b0;
      #1;
      @(negedge in_clk);
      reset_n = 1'b1;
      cyc(2);
      do_start(2'b10, 1'b1, 16'd0);
      repeat (7) do_step();
      check_state("pre reset", 4'b1001, 1'b1, 16'h0007);
      step_clk = 1'b1;
      cyc(1);
      #2;
      reset_n = 1'b0;
      #1;
      check_state("mid reset", 4'b0000, 1'b0, 16'h0000);
      step_clk = 1'b0;
      @(negedge in_clk);
      reset_n = 1'b1;
      cyc(3);
      do_start(2'b01, 1'b1, 16'd1);
      chk("resume start coils", 32'(coils), 32'b1100);
      done_seen = 0;
      do_step();
      check_state("resume step", 4'b0110, 1'b0, 16'h0001);
      chk("resume done", 32'(done_seen), 32'd1);

      // Stop in idle produces no done
      done_seen = 0;
      do_stop();
      chk("idle stop done", 32'(done_seen), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
